// File: rtl/fxp_divider.sv
// fxp_divider: iterative signed QN.Q divider, one restoring step per clock,
// with saturation and divide-by-zero handling.
//
// Ports:
//   i_clk, i_rst   clock (rising edge), asynchronous active-high reset
//   i_start        request; sampled only in IDLE
//   i_A, i_B       signed QN.Q dividend / divisor, latched with i_start
//   o_C            signed QN.Q quotient, held until the next completion
//   o_busy         high in DIV/FIN, and in DONE on the divide-by-zero path
//   o_done         one-cycle completion pulse
//   o_ovf, o_dbz   saturation / divide-by-zero flags, held with o_C
module fxp_divider #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    output logic [N-1:0] o_C,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ovf,
    output logic         o_dbz
);

    localparam int NQ = N + Q;
    localparam int CW = $clog2(NQ + 1);

    localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MINN = {1'b1, {(N-1){1'b0}}};
    localparam logic [NQ-1:0] LIMP = NQ'(MAXP);
    localparam logic [NQ-1:0] LIMN = NQ'(MINN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NQ-1:0] quot_q, quot_d;
    logic [N:0]    rem_q, rem_d;
    logic [N-1:0]  magb_q, magb_d;
    logic          neg_q, neg_d;
    logic [N-1:0]  c_q, c_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;

    logic [N-1:0]  mag_a, mag_b, qlo;
    logic [N:0]    rem_sh, rem_sub;
    logic          ge;

    // 0x8000 maps to an unsigned magnitude of 2^(N-1), which still fits N bits.
    assign mag_a = i_A[N-1] ? (~i_A + ONE) : i_A;
    assign mag_b = i_B[N-1] ? (~i_B + ONE) : i_B;

    // The quotient register starts out holding the shifted dividend; its MSB
    // feeds the remainder while quotient bits fill in from the bottom.
    assign rem_sh  = (rem_q << 1) | {{N{1'b0}}, quot_q[NQ-1]};
    assign ge      = rem_sh >= {1'b0, magb_q};
    assign rem_sub = rem_sh - {1'b0, magb_q};
    assign qlo     = quot_q[N-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            magb_q  <= '0;
            neg_q   <= 1'b0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            magb_q  <= magb_d;
            neg_q   <= neg_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        magb_d  = magb_q;
        neg_d   = neg_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    neg_d  = i_A[N-1] ^ i_B[N-1];
                    magb_d = mag_b;
                    quot_d = NQ'(mag_a) << Q;
                    rem_d  = '0;
                    if (i_B == '0) begin
                        c_d     = i_A[N-1] ? MINN : MAXP;
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CW'(NQ);
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (ge) begin
                    rem_d  = rem_sub;
                    quot_d = {quot_q[NQ-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh;
                    quot_d = {quot_q[NQ-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                dbz_d = 1'b0;
                ovf_d = 1'b0;
                if (!neg_q) begin
                    if (quot_q > LIMP) begin
                        c_d   = MAXP;
                        ovf_d = 1'b1;
                    end else begin
                        c_d = qlo;
                    end
                end else begin
                    // Magnitude exactly 2^(N-1) is representable as MINN.
                    if (quot_q > LIMN) begin
                        c_d   = MINN;
                        ovf_d = 1'b1;
                    end else begin
                        c_d = ~qlo + ONE;
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_C    = c_q;
    assign o_ovf  = ovf_q;
    assign o_dbz  = dbz_q;
    assign o_done = (state_q == S_DONE);
    assign o_busy = (state_q == S_DIV) || (state_q == S_FIN) ||
                    ((state_q == S_DONE) && dbz_q);

endmodule

// File: doc/fxp_divider.md
Name: fxp_divider

Overview:
- Iterative signed fixed-point divider computing o_C = i_A / i_B in QN.Q format (Q8.8 by default).
- Inverse operation to the FFT datapath's fixed-point multiplier; used for normalisation and scaling of FFT bins.
- Sign-magnitude restoring division, one quotient bit per clock.
- Start/busy/done handshake, saturation on overflow, divide-by-zero flag.

Parameters:
- N, 16, total word width (two's complement).
- Q, 8, fractional bits; must satisfy 0 ≤ Q < N.

Ports:
- i_clk  input  1  clock, rising-edge active
- i_rst  input  1  reset; asynchronous, active-high
- i_start  input  1  request pulse; sampled only when o_busy=0
- i_A  input  N  dividend, signed QN.Q; sampled with i_start
- i_B  input  N  divisor, signed QN.Q; sampled with i_start
- o_C  output  N  quotient, signed QN.Q; held until the next completion
- o_busy  output  1  division in progress
- o_done  output  1  one-cycle pulse; o_C and flags are valid from this cycle
- o_ovf  output  1  result saturated; valid with o_done, held
- o_dbz  output  1  divide by zero; valid with o_done, held

Behaviour:
- Reset (asynchronous, any state, including mid-division):
  - State returns to IDLE.
  - o_C=0, o_busy=0, o_done=0, o_ovf=0, o_dbz=0; all internal registers cleared.
  - An aborted division produces no o_done.
- States:
  - IDLE: i_start=1 latches operands.
    - If i_B=0, go to DONE.
    - Otherwise go to DIV with iteration counter = N+Q.
  - DIV: one restoring step per clock.
    - Remainder shifts left by 1 and takes the next dividend MSB.
    - If remainder ≥ divisor, subtract and set quotient bit to 1; otherwise the bit is 0.
    - Counter decrements each step; after N+Q steps, go to FIN.
  - FIN: apply sign and saturation; register o_C and flags; go to DONE.
  - DONE: o_done=1 for exactly this cycle; return to IDLE.
- o_busy=1 in DIV and FIN, and during DONE only on the divide-by-zero path; 0 in IDLE.
- i_start while o_busy=1 or in DONE is ignored; no queuing.
- Arithmetic:
  - magA = |i_A| and magB = |i_B| as N-bit unsigned; 0x8000 maps to magnitude 32768.
  - Dividend = magA << Q (N+Q bits). Quotient register is N+Q bits; remainder is N+1 bits.
  - Quotient is truncated toward zero; no rounding.
  - Result sign = i_A[N-1] XOR i_B[N-1].
- Saturation:
  - Positive result: if mag > 2^(N-1)-1, o_C=0x7FFF and o_ovf=1.
  - Negative result: if mag > 2^(N-1), o_C=0x8000 and o_ovf=1. If mag = 2^(N-1), o_C=0x8000 and o_ovf=0.
  - Magnitude 0 gives o_C=0 regardless of sign.
- Divide by zero:
  - o_dbz=1, o_ovf=0.
  - o_C=0x7FFF if i_A[N-1]=0 (this includes A=0); o_C=0x8000 if i_A is negative.
- Latency:
  - Normal path: start edge to o_done = N+Q+2 rising edges (26 for defaults).
  - Divide-by-zero path: 1 edge.
- Throughput: a new i_start is accepted in the cycle after o_done (IDLE).
- Outputs o_C/o_ovf/o_dbz change only at the FIN/DONE register update or at reset.

Test Plan:
- A=0x0300 (3.0), B=0x0200 (2.0), start pulse → o_done exactly 26 edges later, o_C=0x0180 (1.5), o_ovf=0, o_dbz=0; o_busy high throughout.
- Sign combinations:
  - A=0xFD00, B=0x0200 → o_C=0xFE80.
  - A=0xFF00, B=0xFC00 → 0x0040.
  - A=0x0001, B=0xFE00 → 0x0000.
- Precision and saturation:
  - A=0x0100, B=0x0003 → o_C=0x5555, o_ovf=0.
  - A=0x4000, B=0x0080 → 0x7FFF, o_ovf=1.
  - A=0x8000, B=0x0100 → 0x8000, o_ovf=0.
  - A=0x8000, B=0xFF00 → 0x7FFF, o_ovf=1.
- Divide by zero:
  - A=0xFF00, B=0 → o_done after 1 edge, o_C=0x8000, o_dbz=1.
  - A=0, B=0 → o_C=0x7FFF, o_dbz=1.
- Handshake: second start with different operands at cycle 5 of a busy division → ignored, first result unaffected; start issued the cycle after o_done → accepted, correct result.
- Reset: assert i_rst at DIV cycle 10 (async, mid-clock) → all outputs 0 immediately, no o_done; after release, A=0x0200, B=0x0100 → o_C=0x0200.
